// File: rtl/ff_pkg.sv
// ff_pkg: shared Q16.16 and accumulator types, sequencer state encoding,
// and the fixed-point multiply / saturate helpers.
package ff_pkg;
    localparam int Q_W    = 32;
    localparam int A_W    = 64;
    localparam int Q_FRAC = 16;
    typedef logic signed [Q_W-1:0] q16_t;
    typedef logic signed [A_W-1:0] acc_t;
    typedef logic [1:0] state_t;
    localparam state_t S_IDLE  = 2'd0;
    localparam state_t S_RUN   = 2'd1;
    localparam state_t S_DRAIN = 2'd2;
    localparam state_t S_OUT   = 2'd3;
    localparam acc_t SAT_HI = acc_t'(q16_t'(32'h7FFF_FFFF));
    localparam acc_t SAT_LO = acc_t'(q16_t'(32'h8000_0000));

    // Full-width signed product, floor-shifted back to the fixed-point scale.
    function automatic acc_t fxp_mul(input q16_t a, input q16_t b, input int frac);
        return (acc_t'(a) * acc_t'(b)) >>> frac;
    endfunction

    function automatic q16_t saturate(input acc_t a);
        acc_t c;
        c = a > SAT_HI ? SAT_HI : a < SAT_LO ? SAT_LO : a;
        return q16_t'(c[Q_W-1:0]);
    endfunction
endpackage

// File: rtl/fxp_mac_pipe.sv
// fxp_mac_pipe: operand capture, registered Q16.16 product, and 64-bit
// accumulate; clr empties the pipe and zeroes the accumulator.
module fxp_mac_pipe
    import ff_pkg::*;
#(
    parameter int FRAC = Q_FRAC
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clr,
    input  logic           in_valid,
    input  logic [Q_W-1:0] w,
    input  logic [Q_W-1:0] x,
    output logic [A_W-1:0] acc
);
    q16_t w_q;
    q16_t x_q;
    acc_t prod;
    logic v1;
    logic v2;
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            v1   <= 1'b0;
            v2   <= 1'b0;
            w_q  <= '0;
            x_q  <= '0;
            prod <= '0;
            acc  <= '0;
        end else begin
            v1 <= in_valid;
            v2 <= v1;
            if (in_valid) begin
                w_q <= q16_t'(w);
                x_q <= q16_t'(x);
            end
            if (v1) prod <= fxp_mul(w_q, x_q, FRAC);
            if (v2) acc <= acc + prod;
        end
    end
endmodule

// File: rtl/layer_mac_sequencer.sv
// layer_mac_sequencer: streams one saturated Q16.16 dot product per neuron.
// Define LAYER_MAC_RELU_EN to clamp negative results to zero.
module layer_mac_sequencer
    import ff_pkg::*;
#(
    parameter int NUM_NEURONS = 256,
    parameter int INPUT_SIZE  = 784,
    parameter int DATA_WIDTH  = 32,
    parameter int ACC_WIDTH   = 64,
    parameter int FRAC_BITS   = 16
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start,
    output logic                                   busy,
    output logic                                   done,
    output logic                                   w_en,
    output logic [$clog2(NUM_NEURONS*INPUT_SIZE)-1:0] w_addr,
    input  logic [DATA_WIDTH-1:0]                  w_rdata,
    output logic                                   x_en,
    output logic [$clog2(INPUT_SIZE)-1:0]          x_addr,
    input  logic [DATA_WIDTH-1:0]                  x_rdata,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [DATA_WIDTH-1:0]                  out_data,
    output logic [$clog2(NUM_NEURONS)-1:0]         out_neuron
);
    localparam int AW = $clog2(NUM_NEURONS*INPUT_SIZE);
    localparam int XW = $clog2(INPUT_SIZE);
    localparam int NW = $clog2(NUM_NEURONS);

    state_t               state;
    logic [AW-1:0]        base;
    logic [XW-1:0]        idx;
    logic [NW-1:0]        neuron;
    logic [1:0]           dcnt;
    logic                 issue_d;
    logic                 fire;
    logic                 last_i;
    logic                 last_n;
    logic                 clr;
    logic [ACC_WIDTH-1:0] acc;
    q16_t                 sat;

    always_comb begin
        busy       = state != S_IDLE;
        w_en       = state == S_RUN;
        x_en       = state == S_RUN;
        w_addr     = state == S_RUN ? base + AW'(idx) : '0;
        x_addr     = state == S_RUN ? idx : '0;
        out_valid  = state == S_OUT;
        fire       = out_valid && out_ready;
        last_i     = idx == XW'(INPUT_SIZE - 1);
        last_n     = neuron == NW'(NUM_NEURONS - 1);
        clr        = (state == S_IDLE && start) || fire;
        sat        = saturate(acc_t'(acc));
`ifdef LAYER_MAC_RELU_EN
        out_data   = out_valid && !sat[Q_W-1] ? sat : '0;
`else
        out_data   = out_valid ? sat : '0;
`endif
        out_neuron = neuron;
    end

    // issue_d marks the cycle the memories present data for a RUN issue.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            base    <= '0;
            idx     <= '0;
            neuron  <= '0;
            dcnt    <= '0;
            issue_d <= 1'b0;
            done    <= 1'b0;
        end else begin
            issue_d <= state == S_RUN;
            done    <= fire && last_n;
            case (state)
                S_IDLE: if (start) begin
                    state  <= S_RUN;
                    base   <= '0;
                    idx    <= '0;
                    neuron <= '0;
                end
                S_RUN: begin
                    idx  <= last_i ? '0 : idx + 1'b1;
                    dcnt <= '0;
                    if (last_i) state <= S_DRAIN;
                end
                S_DRAIN: begin
                    dcnt <= dcnt + 1'b1;
                    if (dcnt == 2'd2) state <= S_OUT;
                end
                default: if (fire) begin
                    state  <= last_n ? S_IDLE : S_RUN;
                    neuron <= last_n ? neuron : neuron + 1'b1;
                    base   <= base + AW'(INPUT_SIZE);
                end
            endcase
        end
    end

    fxp_mac_pipe #(.FRAC(FRAC_BITS)) u_pipe (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .in_valid(issue_d),
        .w       (w_rdata),
        .x       (x_rdata),
        .acc     (acc)
    );
endmodule

// File: tb/tb_layer_mac_sequencer.sv
// tb_layer_mac_sequencer: directed table of two-neuron, four-input passes
// plus reset-abort and backpressure sequences.
module tb_layer_mac_sequencer;
    localparam int NN = 2;
    localparam int IS = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy;
    logic        done;
    logic        w_en;
    logic [2:0]  w_addr;
    logic [31:0] w_rdata;
    logic        x_en;
    logic [1:0]  x_addr;
    logic [31:0] x_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [0:0]  out_neuron;

    int checks = 0;
    int errors = 0;
    int wq[$];
    int xbad = 0;
    int done_cnt = 0;
    logic [31:0] wmem [8];
    logic [31:0] xmem [4];

    typedef struct {
        logic [31:0] w0, w1, x, e0, e1;
        int hold;
        bit glitch;
    } vec_t;
    vec_t vecs [5];

    layer_mac_sequencer #(.NUM_NEURONS(NN), .INPUT_SIZE(IS)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .w_en(w_en), .w_addr(w_addr), .w_rdata(w_rdata),
        .x_en(x_en), .x_addr(x_addr), .x_rdata(x_rdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_neuron(out_neuron)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (w_en) w_rdata <= wmem[w_addr];
        if (x_en) x_rdata <= xmem[x_addr];
    end

    always @(negedge clk) begin
        if (w_en) begin
            wq.push_back(int'(w_addr));
            if (x_addr != w_addr[1:0]) xbad++;
        end
        if (done) done_cnt++;
    end

    function automatic logic [31:0] fix(input logic [31:0] e);
`ifdef LAYER_MAC_RELU_EN
        return e[31] ? 32'h0 : e;
`else
        return e;
`endif
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic load(input vec_t v);
        for (int a = 0; a < 4; a++) begin
            wmem[a]     = v.w0;
            wmem[a + 4] = v.w1;
            xmem[a]     = v.x;
        end
    endtask

    task automatic run_pass(input vec_t v, input int id);
        int cnt;
        int xb0;
        int d0;
        bit ok;
        load(v);
        wq.delete();
        xb0 = xbad;
        d0 = done_cnt;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int n = 0; n < NN; n++) begin
            cnt = 0;
            while (!out_valid && cnt < 40) begin
                start = v.glitch && cnt == 2;
                @(negedge clk);
                cnt++;
            end
            start = 1'b0;
            check($sformatf("v%0d n%0d latency", id, n), 64'(cnt), 64'd7);
            for (int k = 0; k < v.hold; k++) begin
                @(negedge clk);
                check($sformatf("v%0d n%0d hold%0d", id, n, k), {out_data, out_valid, w_en, x_en},
                      {fix(n == 0 ? v.e0 : v.e1), 3'b100});
            end
            check($sformatf("v%0d n%0d data", id, n), out_data, fix(n == 0 ? v.e0 : v.e1));
            check($sformatf("v%0d n%0d neuron", id, n), out_neuron, 64'(n));
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            if (n == 0) check($sformatf("v%0d next start", id), {busy, w_en, w_addr}, {1'b1, 1'b1, 3'd4});
            else check($sformatf("v%0d done", id), {busy, done}, 2'b01);
        end
        @(negedge clk);
        check($sformatf("v%0d done one-shot", id), {busy, done}, 2'b00);
        ok = wq.size() == 8;
        for (int a = 0; a < 8; a++) if (ok && wq[a] != a) ok = 1'b0;
        check($sformatf("v%0d w_addr seq", id), 64'(ok), 64'd1);
        check($sformatf("v%0d x_addr track", id), 64'(xbad - xb0), 64'd0);
        check($sformatf("v%0d done count", id), 64'(done_cnt - d0), 64'd1);
    endtask

    initial begin
        int cnt;
        int d0;
        vecs[0] = '{32'h0001_0000, 32'h0001_0000, 32'h0000_8000, 32'h0002_0000, 32'h0002_0000, 0, 1'b0};
        vecs[1] = '{32'h7FFF_0000, 32'h7FFF_0000, 32'h0002_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 10, 1'b0};
        vecs[2] = '{32'h8001_0000, 32'h8001_0000, 32'h0002_0000, 32'h8000_0000, 32'h8000_0000, 0, 1'b1};
        vecs[3] = '{32'h0003_0000, 32'h0000_8000, 32'h0001_8000, 32'h0012_0000, 32'h0003_0000, 0, 1'b0};
        vecs[4] = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_8000, 32'h0000_0000, 32'hFFFF_FFFC, 3, 1'b0};
        rst = 1'b1;
        start = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset outputs", {busy, done, w_en, x_en, w_addr, x_addr, out_valid, out_data, out_neuron}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        for (int v = 0; v < 5; v++) run_pass(vecs[v], v);
        // Abort in the middle of neuron 1's RUN phase.
        load(vecs[0]);
        d0 = done_cnt;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cnt = 0;
        while (!out_valid && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        check("abort n0 latency", 64'(cnt), 64'd7);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        @(negedge clk);
        check("abort in run", {busy, w_en, w_addr}, {1'b1, 1'b1, 3'd5});
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort outputs", {busy, done, w_en, x_en, w_addr, x_addr, out_valid, out_data, out_neuron}, 64'd0);
        repeat (12) @(negedge clk);
        check("abort no done", 64'(done_cnt - d0), 64'd0);
        check("abort idle", {busy, w_en, out_valid}, 3'b000);
        run_pass(vecs[0], 9);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/layer_mac_sequencer.md
Name: layer_mac_sequencer

Overview:
- Forward-pass consumer of a layer's dual-port weight memory. Drives the memory's read-only port A and an input-activation buffer.
- Computes one Q16.16 dot product per neuron (weights · activations) and emits per-neuron pre-activations over a valid/ready stream.
- Result stream feeds the goodness and plasticity stages downstream.

Parameters:
- NUM_NEURONS, 256, neurons in the layer
- INPUT_SIZE, 784, weights per neuron / activation vector length
- DATA_WIDTH, 32, Q16.16 word width
- ACC_WIDTH, 64, signed accumulator width
- FRAC_BITS, 16, fractional bits of the fixed-point format

Ports:
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a full-layer pass
- busy  out  1  high from the accepted start until done
- done  out  1  one-cycle pulse after the last neuron's handshake
- w_en  out  1  to memory en_a
- w_addr  out  $clog2(NUM_NEURONS*INPUT_SIZE)  to memory addr_a
- w_rdata  in  DATA_WIDTH  from memory rdata_a; 1-cycle read latency
- x_en  out  1  activation buffer read enable
- x_addr  out  $clog2(INPUT_SIZE)  activation index
- x_rdata  in  DATA_WIDTH  activation; 1-cycle read latency
- out_valid  out  1  result valid
- out_ready  in  1  downstream accept
- out_data  out  DATA_WIDTH  saturated Q16.16 pre-activation
- out_neuron  out  $clog2(NUM_NEURONS)  neuron index of out_data

Behaviour:
- Reset values:
  - State is IDLE.
  - All outputs are 0.
  - Counters, accumulator and pipeline valid bits are cleared.
  - Reset mid-pass aborts with no done pulse.
- States: IDLE, RUN, DRAIN, OUT.
- IDLE:
  - start → RUN; neuron=0, base=0, i=0, acc=0, busy=1.
  - start is ignored in every other state.
- RUN:
  - Each cycle: w_en=x_en=1, w_addr=base+i, x_addr=i, i++.
  - base is an incrementing register; no multiplier is used for addressing.
  - After issuing i=INPUT_SIZE-1 → DRAIN.
- Pipeline:
  - Stage 1 captures w_rdata/x_rdata one cycle after issue.
  - Stage 2 registers the signed 64-bit product, arithmetic-shifted right by FRAC_BITS (floor).
  - Stage 3 adds the sign-extended product into acc.
- DRAIN:
  - Lasts exactly 3 cycles with no issue, then → OUT.
  - out_valid rises exactly INPUT_SIZE+3 cycles after the first RUN cycle of that neuron.
- OUT:
  - out_valid=1; out_data = acc saturated to the signed DATA_WIDTH range (0x7FFFFFFF / 0x80000000).
  - out_data and out_neuron hold stable until the handshake.
  - On out_valid && out_ready:
    - Last neuron → IDLE; busy=0, done=1 for one cycle.
    - Otherwise: neuron++, base+=INPUT_SIZE, i=0, acc=0, → RUN the next cycle.
- out_ready may stay low indefinitely; nothing is issued while in OUT.
- Accumulator overflow wraps at ACC_WIDTH; it is unreachable at default sizes.
- The module never writes memory.

Optional Feature:
- Macro: LAYER_MAC_RELU_EN.
- Defined: out_data is clamped to 0 when the saturated result is negative (ReLU).
- Undefined: the signed saturated result passes through unchanged.

Decomposition:
- Shared package ff_pkg holds:
  - the Q16.16 typedef (DATA_WIDTH, FRAC_BITS)
  - the accumulator typedef
  - the state enum
  - the saturate function and the fixed-point multiply function
- One natural sub-module: fxp_mac_pipe, covering pipeline stages 1–3 (operands in, valid in, clear, acc out).

Test Plan:
- NUM_NEURONS=2, INPUT_SIZE=4; all weights 1.0 (0x00010000), activations 0.5 (0x00008000):
  - out_data=0x00020000 for neurons 0 and 1
  - w_addr sequence 0..3 then 4..7
  - done pulses one cycle after the second handshake.
- Same setup, measure timing: out_valid rises exactly 7 cycles after the first RUN cycle.
- Weights 0x7FFF0000, activations 0x00020000 (2.0): out_data=0x7FFFFFFF.
  - Negated weights give 0x80000000, or 0 with LAYER_MAC_RELU_EN.
- Backpressure:
  - Hold out_ready=0 for 10 cycles in OUT: out_data stable, w_en=0 throughout.
  - Release: the next neuron starts the following cycle.
- Assert rst during neuron 1 RUN: next cycle all outputs 0, state IDLE, no done.
  - A fresh start then restarts at neuron 0 with w_addr=0.
- Pulse start while busy: ignored; result sequence identical to the uninterrupted run.
